// File: rtl/csr_access_unit.sv
// csr_access_unit: initiator side of the CSR access interface.
// Accepts one decoded Zicsr instruction at a time, reads the addressed CSR,
// optionally issues one write strobe with the RW/RS/RC result, and returns
// the old CSR value (or an illegal-instruction flag) over valid/ready.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake (ready only when idle)
//   funct3_i, csr_adr_i         Zicsr funct3 and target CSR address
//   rs1_idx_i, rs1_data_i       rs1 index (zimm for immediate forms), rs1 value
//   rd_idx_i                    destination register index
//   csr_adr_o                   address to the CSR file
//   csr_rdata_i, csr_illegal_i  combinational read data / unimplemented flag
//   csr_wr_en_o, csr_wdata_o    single-cycle write strobe and value
//   resp_valid_o / resp_ready_i response handshake
//   resp_rd_idx_o, resp_rd_we_o, resp_rd_data_o, resp_illegal_o  response
//   flush_i                     pipeline kill
module csr_access_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [CSR_AW-1:0] csr_adr_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        rd_idx_i,
  output logic [CSR_AW-1:0] csr_adr_o,
  input  logic [XLEN-1:0]   csr_rdata_i,
  input  logic              csr_illegal_i,
  output logic              csr_wr_en_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [4:0]        resp_rd_idx_o,
  output logic              resp_rd_we_o,
  output logic [XLEN-1:0]   resp_rd_data_o,
  output logic              resp_illegal_o,
  input  logic              flush_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  // Latched request payload.
  typedef struct packed {
    logic [2:0]        funct3;
    logic [CSR_AW-1:0] adr;
    logic [4:0]        rs1_idx;
    logic [XLEN-1:0]   rs1_data;
    logic [4:0]        rd_idx;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [XLEN-1:0] old_q;
  logic            illegal_q;

  logic            accept;
  logic [XLEN-1:0] src;
  logic            op_rw, op_rs, op_rc, bad_f3, we, illegal_c;

  // Operand and op decode from the latched instruction.
  assign src    = req_q.funct3[2] ? XLEN'(req_q.rs1_idx) : req_q.rs1_data;
  assign op_rw  = (req_q.funct3[1:0] == 2'b01);
  assign op_rs  = (req_q.funct3[1:0] == 2'b10);
  assign op_rc  = (req_q.funct3[1:0] == 2'b11);
  assign bad_f3 = (req_q.funct3[1:0] == 2'b00);
  // Set/clear forms with rs1/zimm of zero are pure reads.
  assign we     = op_rw | (req_q.rs1_idx != 5'd0);
  // Top two address bits 11 mark a read-only CSR.
  assign illegal_c = bad_f3 | csr_illegal_i |
                     (we & (req_q.adr[CSR_AW-1 -: 2] == 2'b11));

  // A flush in IDLE blocks acceptance for that cycle.
  assign accept = req_valid_i & (state_q == IDLE) & ~flush_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = READ;
      READ: begin
        if (flush_i)               state_d = IDLE;
        else if (illegal_c || !we) state_d = RESP;
        else                       state_d = WRITE;
      end
      WRITE: state_d = RESP;  // flush does not cancel a committing write
      RESP:  if (flush_i || resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture on accept; old value and illegal capture in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (accept) begin
        req_q.funct3   <= funct3_i;
        req_q.adr      <= csr_adr_i;
        req_q.rs1_idx  <= rs1_idx_i;
        req_q.rs1_data <= rs1_data_i;
        req_q.rd_idx   <= rd_idx_i;
      end
      if (state_q == READ) begin
        old_q     <= csr_rdata_i;
        illegal_q <= illegal_c;
      end
    end
  end

  // Write value, driven only while the strobe is high.
  always_comb begin
    csr_wdata_o = '0;
    if (state_q == WRITE) begin
      if (op_rw)      csr_wdata_o = src;
      else if (op_rs) csr_wdata_o = old_q | src;
      else if (op_rc) csr_wdata_o = old_q & ~src;
    end
  end

  // Outputs are pure decodes of the state and latched registers.
  assign req_ready_o    = (state_q == IDLE);
  assign csr_wr_en_o    = (state_q == WRITE);
  assign resp_valid_o   = (state_q == RESP);
  assign csr_adr_o      = req_q.adr;
  assign resp_rd_idx_o  = resp_valid_o ? req_q.rd_idx : 5'd0;
  assign resp_rd_data_o = resp_valid_o ? old_q : '0;
  assign resp_illegal_o = resp_valid_o & illegal_q;
  assign resp_rd_we_o   = resp_valid_o & ~illegal_q & (req_q.rd_idx != 5'd0);

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a tiny CSR file model
// (misa = 0x40000100 constant, mvendorid at 0xF11, 0x7C0 unimplemented).
module tb_csr_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  funct3;
  logic [11:0] csr_adr_in;
  logic [4:0]  rs1_idx;
  logic [31:0] rs1_data;
  logic [4:0]  rd_idx;
  logic [11:0] csr_adr;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd_idx;
  logic        resp_rd_we;
  logic [31:0] resp_rd_data;
  logic        resp_illegal;
  logic        flush;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .funct3_i(funct3), .csr_adr_i(csr_adr_in),
    .rs1_idx_i(rs1_idx), .rs1_data_i(rs1_data), .rd_idx_i(rd_idx),
    .csr_adr_o(csr_adr), .csr_rdata_i(csr_rdata), .csr_illegal_i(csr_illegal),
    .csr_wr_en_o(csr_wr_en), .csr_wdata_o(csr_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rd_idx_o(resp_rd_idx), .resp_rd_we_o(resp_rd_we),
    .resp_rd_data_o(resp_rd_data), .resp_illegal_o(resp_illegal),
    .flush_i(flush)
  );

  // CSR file model: combinational read from the issued address.
  always_comb begin
    csr_rdata   = 32'h0;
    csr_illegal = 1'b0;
    case (csr_adr)
      12'h301: csr_rdata   = 32'h4000_0100;
      12'hF11: csr_rdata   = 32'h0000_0601;
      12'h7C0: csr_illegal = 1'b1;
      default: csr_rdata   = 32'h0;
    endcase
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one request at the next edge; returns in cycle 1 (READ).
  task automatic send(input logic [2:0] f3, input logic [11:0] adr,
                      input logic [4:0] ri, input logic [31:0] rdat,
                      input logic [4:0] rdi);
    req_valid = 1'b1; funct3 = f3; csr_adr_in = adr;
    rs1_idx = ri; rs1_data = rdat; rd_idx = rdi;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b exp 1", req_ready); end
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (csr_adr !== 12'h0) begin n_err++; $display("FAIL rst_adr: got %h exp 000", csr_adr); end
    n_cmp++; if (csr_wdata !== 32'h0) begin n_err++; $display("FAIL rst_wdata: got %h exp 0", csr_wdata); end
  endtask

  task automatic test_read_only_op();
    // CSRRS x5, misa, x0
    send(3'b010, 12'h301, 5'd0, 32'hFFFF_FFFF, 5'd5);
    n_cmp++; if (csr_adr !== 12'h301) begin n_err++; $display("FAIL rs_adr: got %h exp 301", csr_adr); end
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rs_c1_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rs_c1_valid: got %b exp 0", resp_valid); end
    step();
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rs_c2_valid: got %b exp 1", resp_valid); end
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rs_c2_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_rd_data !== 32'h4000_0100) begin n_err++; $display("FAIL rs_data: got %h exp 40000100", resp_rd_data); end
    n_cmp++; if (resp_rd_we !== 1'b1) begin n_err++; $display("FAIL rs_rd_we: got %b exp 1", resp_rd_we); end
    n_cmp++; if (resp_rd_idx !== 5'd5) begin n_err++; $display("FAIL rs_rd_idx: got %0d exp 5", resp_rd_idx); end
    n_cmp++; if (resp_illegal !== 1'b0) begin n_err++; $display("FAIL rs_illegal: got %b exp 0", resp_illegal); end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rs_idle: got %b exp 1", req_ready); end
  endtask

  task automatic test_rw();
    // CSRRW x1, misa, rs1 = 0x1234
    send(3'b001, 12'h301, 5'd7, 32'h0000_1234, 5'd1);
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rw_c1_wr: got %b exp 0", csr_wr_en); end
    step();
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_err++; $display("FAIL rw_c2_wr: got %b exp 1", csr_wr_en); end
    n_cmp++; if (csr_wdata !== 32'h0000_1234) begin n_err++; $display("FAIL rw_wdata: got %h exp 00001234", csr_wdata); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rw_c2_valid: got %b exp 0", resp_valid); end
    step();
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rw_c3_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (csr_wdata !== 32'h0) begin n_err++; $display("FAIL rw_c3_wdata: got %h exp 0", csr_wdata); end
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL rw_c3_valid: got %b exp 1", resp_valid); end
    n_cmp++; if (resp_rd_data !== 32'h4000_0100) begin n_err++; $display("FAIL rw_data: got %h exp 40000100", resp_rd_data); end
    n_cmp++; if (resp_rd_idx !== 5'd1) begin n_err++; $display("FAIL rw_rd_idx: got %0d exp 1", resp_rd_idx); end
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rw_idle: got %b exp 1", req_ready); end
  endtask

  task automatic test_immediate();
    // CSRRSI x2, misa, 3 (rs1_data must be ignored)
    send(3'b110, 12'h301, 5'd3, 32'hFFFF_FFFF, 5'd2);
    step();
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_err++; $display("FAIL rsi_wr: got %b exp 1", csr_wr_en); end
    n_cmp++; if (csr_wdata !== 32'h4000_0103) begin n_err++; $display("FAIL rsi_wdata: got %h exp 40000103", csr_wdata); end
    step(); step();
    // CSRRCI x2, misa, 0x1F
    send(3'b111, 12'h301, 5'h1F, 32'h0, 5'd2);
    step();
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_err++; $display("FAIL rci_wr: got %b exp 1", csr_wr_en); end
    n_cmp++; if (csr_wdata !== 32'h4000_0100) begin n_err++; $display("FAIL rci_wdata: got %h exp 40000100", csr_wdata); end
    step();
    n_cmp++; if (resp_rd_data !== 32'h4000_0100) begin n_err++; $display("FAIL rci_data: got %h exp 40000100", resp_rd_data); end
    step();
  endtask

  task automatic test_illegal();
    // CSRRW to read-only mvendorid
    send(3'b001, 12'hF11, 5'd1, 32'h1, 5'd4);
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL ro_c1_wr: got %b exp 0", csr_wr_en); end
    step();
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL ro_valid: got %b exp 1", resp_valid); end
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL ro_c2_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_illegal !== 1'b1) begin n_err++; $display("FAIL ro_illegal: got %b exp 1", resp_illegal); end
    n_cmp++; if (resp_rd_we !== 1'b0) begin n_err++; $display("FAIL ro_rd_we: got %b exp 0", resp_rd_we); end
    step();
    // CSRRS x3, unimplemented 0x7C0
    send(3'b010, 12'h7C0, 5'd0, 32'h0, 5'd3);
    step();
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL unimp_valid: got %b exp 1", resp_valid); end
    n_cmp++; if (resp_illegal !== 1'b1) begin n_err++; $display("FAIL unimp_illegal: got %b exp 1", resp_illegal); end
    n_cmp++; if (resp_rd_we !== 1'b0) begin n_err++; $display("FAIL unimp_rd_we: got %b exp 0", resp_rd_we); end
    step();
    // funct3 = 100 on an otherwise writable CSR
    send(3'b100, 12'h301, 5'd4, 32'h5, 5'd6);
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL badf3_c1_wr: got %b exp 0", csr_wr_en); end
    step();
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL badf3_c2_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_illegal !== 1'b1) begin n_err++; $display("FAIL badf3_illegal: got %b exp 1", resp_illegal); end
    n_cmp++; if (resp_rd_we !== 1'b0) begin n_err++; $display("FAIL badf3_rd_we: got %b exp 0", resp_rd_we); end
    step();
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b0;
    send(3'b010, 12'h301, 5'd0, 32'h0, 5'd8);
    step();
    // Offer a second request while the first response is stalled.
    req_valid = 1'b1; funct3 = 3'b010; csr_adr_in = 12'hF11;
    rs1_idx = 5'd0; rs1_data = 32'h0; rd_idx = 5'd9;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, resp_valid); end
      n_cmp++; if (resp_rd_data !== 32'h4000_0100) begin n_err++; $display("FAIL bp_data[%0d]: got %h exp 40000100", i, resp_rd_data); end
      n_cmp++; if (resp_rd_idx !== 5'd8) begin n_err++; $display("FAIL bp_rd_idx[%0d]: got %0d exp 8", i, resp_rd_idx); end
      n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b exp 0", i, req_ready); end
      n_cmp++; if (csr_adr !== 12'h301) begin n_err++; $display("FAIL bp_adr[%0d]: got %h exp 301", i, csr_adr); end
      step();
    end
    resp_ready = 1'b1;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_after_hs: got %b exp 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_valid: got %b exp 0", resp_valid); end
    step();
    req_valid = 1'b0;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_accepted: got %b exp 0", req_ready); end
    n_cmp++; if (csr_adr !== 12'hF11) begin n_err++; $display("FAIL bp_new_adr: got %h exp f11", csr_adr); end
    step();
    n_cmp++; if (resp_rd_idx !== 5'd9) begin n_err++; $display("FAIL bp2_rd_idx: got %0d exp 9", resp_rd_idx); end
    n_cmp++; if (resp_rd_data !== 32'h0000_0601) begin n_err++; $display("FAIL bp2_data: got %h exp 00000601", resp_rd_data); end
    n_cmp++; if (resp_illegal !== 1'b0) begin n_err++; $display("FAIL bp2_illegal: got %b exp 0", resp_illegal); end
    step();
  endtask

  task automatic test_flush();
    // Flush in READ: nothing happens.
    send(3'b001, 12'h301, 5'd1, 32'h55, 5'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL fr_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fr_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fr_ready: got %b exp 1", req_ready); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fr_late_valid: got %b exp 0", resp_valid); end
    // Flush in WRITE: write commits, response still produced.
    send(3'b001, 12'h301, 5'd1, 32'h55, 5'd1);
    step();
    flush = 1'b1;
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_err++; $display("FAIL fw_wr: got %b exp 1", csr_wr_en); end
    step();
    flush = 1'b0;
    n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL fw_valid: got %b exp 1", resp_valid); end
    step();
    // Flush in RESP: response dropped.
    resp_ready = 1'b0;
    send(3'b010, 12'h301, 5'd0, 32'h0, 5'd2);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; resp_ready = 1'b1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fresp_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fresp_ready: got %b exp 1", req_ready); end
    // Flush in IDLE: request not accepted.
    req_valid = 1'b1; funct3 = 3'b001; csr_adr_in = 12'h7C0;
    rs1_idx = 5'd1; rs1_data = 32'h1; rd_idx = 5'd1; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL fidle_ready: got %b exp 1", req_ready); end
    n_cmp++; if (csr_adr !== 12'h301) begin n_err++; $display("FAIL fidle_adr: got %h exp 301", csr_adr); end
    step();
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fidle_valid: got %b exp 0", resp_valid); end
  endtask

  task automatic test_reset_mid_write();
    send(3'b001, 12'h301, 5'd1, 32'hAA, 5'd1);
    step();
    n_cmp++; if (csr_wr_en !== 1'b1) begin n_err++; $display("FAIL rw_pre_rst_wr: got %b exp 1", csr_wr_en); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (csr_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_wr: got %b exp 0", csr_wr_en); end
    n_cmp++; if (csr_wdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_wdata: got %h exp 0", csr_wdata); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b exp 1", req_ready); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_ready: got %b exp 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rel_valid: got %b exp 0", resp_valid); end
    n_cmp++; if (csr_adr !== 12'h0) begin n_err++; $display("FAIL rst_rel_adr: got %h exp 000", csr_adr); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'b0; csr_adr_in = 12'h0;
    rs1_idx = 5'd0; rs1_data = 32'h0; rd_idx = 5'd0;
    resp_ready = 1'b1; flush = 1'b0;
    #1;
    test_reset();
    step(); step();
    rst_n = 1'b1;
    step();
    test_read_only_op();
    test_rw();
    test_immediate();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Initiator side of the CSR access interface: accepts one decoded Zicsr instruction at a time from the execute stage and runs the read/modify/write sequence against the machine CSR file. It issues the CSR address, samples the CSR file's combinational read data and illegal flag, and issues at most one write strobe carrying the RW/RS/RC-computed value. It returns the old CSR value for rd, or an illegal-instruction flag, over a valid/ready response handshake.

## Interface
- XLEN, 32, data width
- CSR_AW, 12, CSR address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  1  CSR instruction present
- req_ready_o  out  1  unit idle, can accept
- funct3_i  in  3  Zicsr funct3
- csr_adr_i  in  CSR_AW  target CSR address
- rs1_idx_i  in  5  rs1 index; also the zimm source for the immediate forms
- rs1_data_i  in  XLEN  rs1 value
- rd_idx_i  in  5  destination register index
- csr_adr_o  out  CSR_AW  address to the CSR file
- csr_rdata_i  in  XLEN  CSR file read data, combinational from csr_adr_o
- csr_illegal_i  in  1  CSR file reports an unimplemented address
- csr_wr_en_o  out  1  single-cycle write strobe
- csr_wdata_o  out  XLEN  final write value
- resp_valid_o  out  1  response available
- resp_ready_i  in  1  consumer accepts the response
- resp_rd_idx_o  out  5  latched rd index
- resp_rd_we_o  out  1  write rd with resp_rd_data_o
- resp_rd_data_o  out  XLEN  old CSR value
- resp_illegal_o  out  1  raise illegal-instruction exception
- flush_i  in  1  pipeline kill

## Operation
- States: IDLE, READ, WRITE, RESP.
  - req_ready_o = (state == IDLE).
  - csr_wr_en_o = (state == WRITE).
  - resp_valid_o = (state == RESP).
- IDLE: on req_valid_i & req_ready_o, latch funct3, address, rs1_idx, rs1_data, rd_idx. Go to READ.
- Source operand: src = funct3[2] ? {27'b0, rs1_idx} : rs1_data.
- Op decode:
  - funct3[1:0] = 01 is RW, 10 is RS, 11 is RC.
  - funct3 000 or 100 is illegal.
- Write intent (we):
  - RW/RWI: always 1.
  - RS/RC forms: 1 only when rs1_idx != 0.
- READ: csr_adr_o = latched address. Sample csr_rdata_i into old and csr_illegal_i.
  - illegal = bad funct3 | csr_illegal_i | (we & adr[11:10] == 2'b11).
  - illegal or !we: go to RESP.
  - otherwise: go to WRITE.
- WRITE: csr_wdata_o is computed from old:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - Then go to RESP.
- csr_wdata_o = 0 outside WRITE.
- RESP outputs:
  - resp_rd_data_o = old.
  - resp_illegal_o = illegal.
  - resp_rd_we_o = !illegal & (rd_idx != 0).
  - Outputs are held stable until resp_ready_i = 1, then go to IDLE.
- Flush:
  - flush_i in READ: go to IDLE; no write, no response.
  - flush_i in WRITE: ignored (the write commits) and the response is still produced.
  - flush_i in RESP: drop the response and go to IDLE.
  - flush_i in IDLE: no request is accepted that cycle.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State returns to IDLE; all latched fields and outputs are 0.
  - req_ready_o = 1.
  - csr_wr_en_o drops in the same cycle rst_n falls, including when reset hits mid-WRITE.
- Acceptance edge is T0. READ occupies cycle 1.
- With a write: csr_wr_en_o is high for exactly cycle 2; resp_valid_o rises in cycle 3.
- Without a write, or when illegal: resp_valid_o rises in cycle 2.
- The next request can be accepted in the cycle after the response handshake, so back-to-back throughput is one instruction per 3–4 cycles.
- CSR reads have no side effects; a second read of the same CSR is harmless.
- csr_adr_o is stable from cycle 1 until the unit returns to IDLE.

## Test plan
- CSRRS x5, 0x301 (misa), rs1 = x0 → no write strobe; resp_valid_o in cycle 2; resp_rd_data_o = 0x40000100, resp_rd_we_o = 1, resp_rd_idx_o = 5.
- CSRRW x1, 0x301, rs1_data = 0x00001234 → csr_wr_en_o high exactly in cycle 2 with csr_wdata_o = 0x00001234; resp_rd_data_o = 0x40000100.
- CSRRSI/CSRRCI x2, 0x301, zimm 3 / 0x1F → csr_wdata_o = 0x40000103 / 0x40000100.
- Read-only address: CSRRW 0xF11 → resp_illegal_o = 1, no strobe, resp_rd_we_o = 0.
- Unimplemented address: CSRRS x3, 0x7C0 with csr_illegal_i = 1 → resp_illegal_o = 1, resp_rd_we_o = 0.
- Bad funct3 (100) → illegal, no strobe.
- Response backpressure: hold resp_ready_i = 0 for 3 cycles → resp_* outputs stable and req_ready_o = 0 throughout; a request offered then is accepted only after the handshake.
- Flush and reset:
  - flush_i in READ → no strobe, no response, req_ready_o = 1 next cycle.
  - rst_n low mid-WRITE → csr_wr_en_o = 0 immediately; state is IDLE after release.
